// File: rtl/store_buffer.sv
// ============================================================================
// store_buffer : in-order store write buffer between MEM stage and data memory
// Revision     : 1.0
// ============================================================================
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [2:0]    st_width,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic [31:0]   st_pc,
  output logic          st_ready,
  output logic          st_misalign,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  output logic          ld_hazard,
  input  logic          pause,
  output logic          dm_we,
  output logic [2:0]    dm_width,
  output logic [31:0]   dm_addr,
  output logic [31:0]   dm_wdata,
  output logic [31:0]   dm_pc,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    width_q [DEPTH];
  logic [31:0]   addr_q  [DEPTH];
  logic [31:0]   data_q  [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          misaligned;
  logic          enq;
  logic          deq;
  logic [DEPTH-1:0] hit;
  logic          w_unused;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    misaligned = 1'b0;
    case (st_width)
      3'd1:    misaligned = st_addr[0];
      3'd2:    misaligned = 1'b0;
      default: misaligned = |st_addr[1:0];
    endcase
  end

  assign st_misalign = st_valid & misaligned;
  assign st_ready    = ~full;
  assign enq         = st_valid & ~full & ~misaligned;
  assign deq         = ~empty & ~pause;

  assign dm_we    = deq;
  assign dm_width = empty ? 3'd0  : width_q[head_q];
  assign dm_addr  = empty ? 32'd0 : addr_q[head_q];
  assign dm_wdata = empty ? 32'd0 : data_q[head_q];
  assign dm_pc    = empty ? 32'd0 : pc_q[head_q];

  // An entry is live when its distance from head is below count; the head
  // entry still counts even while it drains this cycle.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [PW-1:0] off;
    assign off    = PW'(i) - head_q;
    assign hit[i] = (CW'(off) < count_q) && (addr_q[i][31:2] == ld_addr[31:2]);
  end

  assign ld_hazard = ld_valid & (|hit);
  assign w_unused  = ^ld_addr[1:0];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PW'(1);
    if (deq) head_d = head_q + PW'(1);
    if (enq && !deq)      count_d = count_q + CW'(1);
    else if (!enq && deq) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      width_q[tail_q] <= st_width;
      addr_q[tail_q]  <= st_addr;
      data_q[tail_q]  <= st_data;
      pc_q[tail_q]    <= st_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// tb_store_buffer : directed scoreboard bench for store_buffer
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic [2:0]    st_width;
  logic [31:0]   st_addr, st_data, st_pc;
  logic          st_ready, st_misalign;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          ld_hazard;
  logic          pause;
  logic          dm_we;
  logic [2:0]    dm_width;
  logic [31:0]   dm_addr, dm_wdata, dm_pc;
  logic [CW-1:0] count;
  logic          empty;

  typedef struct packed {
    logic [2:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] pc;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  nwrites = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n),
    .st_valid(st_valid), .st_width(st_width), .st_addr(st_addr),
    .st_data(st_data), .st_pc(st_pc), .st_ready(st_ready),
    .st_misalign(st_misalign), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_hazard(ld_hazard), .pause(pause), .dm_we(dm_we),
    .dm_width(dm_width), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_pc(dm_pc), .count(count), .empty(empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] pc,
                          input bit expect_write);
    st_valid = 1'b1; st_width = w; st_addr = a; st_data = d; st_pc = pc;
    if (expect_write) exp_q.push_back('{w: w, a: a, d: d, pc: pc});
  endtask

  task automatic idle_st();
    st_valid = 1'b0; st_width = 3'd0; st_addr = '0; st_data = '0; st_pc = '0;
  endtask

  // Each DM write is seen once per cycle, between the edges.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dm_we === 1'b1) begin
      nwrites++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", dm_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr",  dm_addr,  e.a);
        chk("wr_data",  dm_wdata, e.d);
        chk("wr_pc",    dm_pc,    e.pc);
        chk("wr_width", {29'd0, dm_width}, {29'd0, e.w});
      end
    end
  end

  initial begin
    int w0;
    rst_n = 1'b0; pause = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    idle_st();
    #3;
    chk("rst_count",    {29'd0, count}, 32'd0);
    chk("rst_empty",    {31'd0, empty}, 32'd1);
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_dm_we",    {31'd0, dm_we}, 32'd0);
    chk("rst_dm_addr",  dm_addr, 32'd0);
    chk("rst_ld_hazard",{31'd0, ld_hazard}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single store
    drive_st(3'd0, 32'h10, 32'hDEADBEEF, 32'h3000, 1'b1);
    tick(); idle_st(); #1;
    chk("single_dm_we",   {31'd0, dm_we}, 32'd1);
    chk("single_dm_addr", dm_addr, 32'h10);
    chk("single_count",   {29'd0, count}, 32'd1);
    tick();
    chk("single_empty",   {31'd0, empty}, 32'd1);

    // fill and drain with an overflow attempt
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_st(3'd0, 32'(i * 4), 32'hA000_0000 + 32'(i), 32'h4000 + 32'(i * 4), 1'b1);
      tick();
    end
    idle_st(); #1;
    chk("fill_count",    {29'd0, count}, 32'd4);
    chk("fill_st_ready", {31'd0, st_ready}, 32'd0);
    chk("fill_paused_we",{31'd0, dm_we}, 32'd0);
    drive_st(3'd0, 32'h20, 32'h2020_2020, 32'h4020, 1'b0);
    tick(); idle_st(); #1;
    chk("overflow_count", {29'd0, count}, 32'd4);
    w0 = nwrites;
    pause = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_empty",  {31'd0, empty}, 32'd1);
    chk("drain_writes", 32'(nwrites - w0), 32'd4);

    // load hazard, word granular
    pause = 1'b1;
    drive_st(3'd2, 32'h24, 32'h0000_00AB, 32'h5000, 1'b1);
    tick(); idle_st();
    ld_valid = 1'b1; ld_addr = 32'h26; #1;
    chk("hazard_hit",  {31'd0, ld_hazard}, 32'd1);
    ld_addr = 32'h28; #1;
    chk("hazard_miss", {31'd0, ld_hazard}, 32'd0);
    ld_addr = 32'h24; ld_valid = 1'b0; #1;
    chk("hazard_noval",{31'd0, ld_hazard}, 32'd0);
    pause = 1'b0;
    ld_valid = 1'b1; #1;
    chk("hazard_draining", {31'd0, ld_hazard}, 32'd1);
    tick(); ld_valid = 1'b0; #1;
    chk("hazard_after_drain_empty", {31'd0, empty}, 32'd1);

    // misaligned requests
    drive_st(3'd1, 32'h11, 32'h1111, 32'h6000, 1'b0); #1;
    chk("mis_half", {31'd0, st_misalign}, 32'd1);
    tick();
    chk("mis_half_count", {29'd0, count}, 32'd0);
    drive_st(3'd0, 32'h12, 32'h1212, 32'h6004, 1'b0); #1;
    chk("mis_word", {31'd0, st_misalign}, 32'd1);
    tick();
    chk("mis_word_count", {29'd0, count}, 32'd0);
    drive_st(3'd5, 32'h16, 32'h1616, 32'h6006, 1'b0); #1;
    chk("mis_badcode", {31'd0, st_misalign}, 32'd1);
    pause = 1'b1;
    drive_st(3'd2, 32'h13, 32'h0000_0013, 32'h6008, 1'b1); #1;
    chk("byte_ok", {31'd0, st_misalign}, 32'd0);
    tick(); idle_st(); #1;
    chk("byte_count", {29'd0, count}, 32'd1);
    pause = 1'b0;
    tick();
    chk("byte_drained", {31'd0, empty}, 32'd1);

    // full with drain: a full buffer rejects even while it drains
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_st(3'd0, 32'h40 + 32'(i * 4), 32'hB000_0000 + 32'(i), 32'h7000 + 32'(i * 4), 1'b1);
      tick();
    end
    pause = 1'b0;
    drive_st(3'd0, 32'h50, 32'hB000_0050, 32'h7050, 1'b0); #1;
    chk("fd_ready_low", {31'd0, st_ready}, 32'd0);
    chk("fd_dm_we",     {31'd0, dm_we}, 32'd1);
    tick();
    chk("fd_count3",    {29'd0, count}, 32'd3);
    chk("fd_ready_hi",  {31'd0, st_ready}, 32'd1);
    exp_q.push_back('{w: 3'd0, a: 32'h50, d: 32'hB000_0050, pc: 32'h7050});
    tick(); idle_st(); #1;
    chk("fd_accepted_count", {29'd0, count}, 32'd3);
    begin
      int n;
      n = 0;
      while (empty !== 1'b1 && n < 20) begin tick(); n++; end
      chk("fd_drain_timeout", {31'd0, empty}, 32'd1);
    end
    chk("fd_queue_empty", 32'(exp_q.size()), 32'd0);

    // asynchronous reset mid-operation
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_st(3'd0, 32'h60 + 32'(i * 4), 32'hC000_0000 + 32'(i), 32'h8000, 1'b0);
      tick();
    end
    idle_st(); #1;
    chk("ar_count3", {29'd0, count}, 32'd3);
    #1 rst_n = 1'b0; #1;
    chk("ar_count0",   {29'd0, count}, 32'd0);
    chk("ar_dm_we",    {31'd0, dm_we}, 32'd0);
    chk("ar_st_ready", {31'd0, st_ready}, 32'd1);
    chk("ar_dm_addr",  dm_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1; pause = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    drive_st(3'd1, 32'h72, 32'h0000_7272, 32'h9000, 1'b1);
    tick(); idle_st();
    tick(); tick();
    chk("ar_final_empty", {31'd0, empty}, 32'd1);
    chk("ar_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
